// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with burst locking that shares one fifo write port among
// several producers; a winner keeps the port until a last beat or MaxBurst beats.
module fifo_write_arbiter #(
  parameter int NumRequesters = 4,
  parameter int EntrySize     = 8,
  parameter int MaxBurst      = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumRequesters-1:0]           req_valid_i,
  input  logic [NumRequesters-1:0]           req_last_i,
  input  logic [NumRequesters*EntrySize-1:0] req_data_i,
  output logic [NumRequesters-1:0]           req_ready_o,
  output logic [NumRequesters-1:0]           grant_o,
  output logic                               fifo_write_req_o,
  input  logic                               fifo_write_valid_i,
  output logic [EntrySize-1:0]               fifo_data_o
);

  localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int CntW = $clog2(MaxBurst + 1);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t                   state_reg, state_next;
  logic [NumRequesters-1:0] grant_reg, grant_next;
  logic [CntW-1:0]          beat_cnt_reg, beat_cnt_next;
  logic [IdxW-1:0]          rr_ptr_reg, rr_ptr_next;

  logic [EntrySize-1:0]     data_arr [NumRequesters];
  logic [IdxW-1:0]          win_idx;
  logic                     win_found;
  logic                     beat;
  logic                     burst_done;

  generate
    for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_unpack
      assign data_arr[gi] = req_data_i[gi*EntrySize +: EntrySize];
    end
  endgenerate

  // First valid requester strictly after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NumRequesters; i++) begin
      if (!win_found && req_valid_i[IdxW'((int'(rr_ptr_reg) + i) % NumRequesters)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'((int'(rr_ptr_reg) + i) % NumRequesters);
      end
    end
  end

  // While GRANTED, rr_ptr_reg holds the granted index, so it doubles as the mux select.
  assign beat       = (state_reg == GRANTED) && req_valid_i[rr_ptr_reg] && fifo_write_valid_i;
  assign burst_done = req_last_i[rr_ptr_reg] || ((beat_cnt_reg + 1'b1) == CntW'(MaxBurst));
  assign grant_o    = grant_reg;

  always_comb begin
    req_ready_o      = '0;
    fifo_write_req_o = 1'b0;
    fifo_data_o      = '0;
    if (state_reg == GRANTED) begin
      fifo_write_req_o = req_valid_i[rr_ptr_reg];
      fifo_data_o      = data_arr[rr_ptr_reg];
      req_ready_o      = grant_reg & {NumRequesters{beat}};
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    beat_cnt_next = beat_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next    = GRANTED;
          grant_next    = NumRequesters'(1) << win_idx;
          rr_ptr_next   = win_idx;
          beat_cnt_next = '0;
        end
      end
      GRANTED: begin
        if (beat) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (burst_done) begin
            state_next = IDLE;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      beat_cnt_reg <= '0;
      rr_ptr_reg   <= IdxW'(NumRequesters - 1);
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      beat_cnt_reg <= beat_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: producer queues feed the DUT, expected
// fifo writes are queued per scenario and popped as the DUT writes.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic           fifo_write_req, fifo_write_valid;
  logic [W-1:0]   fifo_data;

  int checks = 0;
  int failures = 0;

  logic [W:0]   pq [N][$];
  logic [W-1:0] sb [$];
  logic [N-1:0] grant_seq [$];
  logic [N-1:0] grant_hist [$];
  logic [N-1:0] ready_hist [$];
  int           burst_len [$];
  int           idle_pending, stall_seen, stall_bad;

  fifo_write_arbiter #(.NumRequesters(N), .EntrySize(W), .MaxBurst(MB)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid),
    .req_last_i         (req_last),
    .req_data_i         (req_data),
    .req_ready_o        (req_ready),
    .grant_o            (grant),
    .fifo_write_req_o   (fifo_write_req),
    .fifo_write_valid_i (fifo_write_valid),
    .fifo_data_o        (fifo_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int k = 0; k < N; k++) pq[k].delete();
    sb.delete();
    grant_seq.delete();
    grant_hist.delete();
    ready_hist.delete();
    burst_len.delete();
    idle_pending = 0;
    stall_seen   = 0;
    stall_bad    = 0;
  endtask

  task automatic apply_reset();
    clear_model();
    rst_ni = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_write_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic add_beat(input int k, input logic [W-1:0] d, input logic last);
    pq[k].push_back({last, d});
  endtask

  // Drives producers cycle by cycle until every queue drains or the budget expires.
  task automatic run_traffic(input int max_cycles, input int stall_at, input int stall_len);
    int cyc = 0;
    int beats = 0;
    int stall_left = stall_len;
    int pending;
    logic [N-1:0] prev_grant = '0;
    logic [W-1:0] exp_d;
    logic [W:0]   fr;
    logic         wr;
    forever begin
      pending = 0;
      for (int k = 0; k < N; k++) begin
        pending += pq[k].size();
        if (pq[k].size() > 0) begin
          fr = pq[k][0];
          req_valid[k] = 1'b1;
          req_last[k] = fr[W];
          req_data[k*W +: W] = fr[W-1:0];
        end else begin
          req_valid[k] = 1'b0;
          req_last[k] = 1'b0;
          req_data[k*W +: W] = '0;
        end
      end
      fifo_write_valid = !(beats == stall_at && stall_left > 0);
      #1;
      grant_hist.push_back(grant);
      ready_hist.push_back(req_ready);
      if (pending == 0 && sb.size() == 0) break;
      if (cyc >= max_cycles) begin
        checks++; failures++;
        $display("FAIL timeout: outstanding=%0d after %0d cycles, required 0", sb.size(), cyc);
        break;
      end
      wr = fifo_write_req && fifo_write_valid;
      checks++;
      if ($countones(grant) > 1) begin
        failures++;
        $display("FAIL grant_onehot: grant=%b, required one-hot or zero", grant);
      end
      checks++;
      if (req_ready !== (wr ? grant : '0)) begin
        failures++;
        $display("FAIL ready: req_ready=%b, required %b", req_ready, wr ? grant : '0);
      end
      checks++;
      if (fifo_write_req !== |(grant & req_valid)) begin
        failures++;
        $display("FAIL write_req: fifo_write_req=%b, required %b", fifo_write_req, |(grant & req_valid));
      end
      if (grant == '0 && req_valid != '0) idle_pending++;
      if (grant != '0 && prev_grant == '0) begin
        grant_seq.push_back(grant);
        burst_len.push_back(0);
      end
      if (!fifo_write_valid) begin
        stall_seen++;
        stall_left--;
        if (req_ready != '0 || grant != prev_grant || grant == '0) stall_bad++;
      end
      if (wr) begin
        beats++;
        if (burst_len.size() > 0)
          burst_len[burst_len.size()-1] = burst_len[burst_len.size()-1] + 1;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: data=%h, required no write", fifo_data);
        end else begin
          exp_d = sb.pop_front();
          if (fifo_data !== exp_d) begin
            failures++;
            $display("FAIL data: fifo_data=%h, required %h", fifo_data, exp_d);
          end
        end
        $display("write t=%0t grant=%b data=%h", $time, grant, fifo_data);
        for (int k = 0; k < N; k++)
          if (req_ready[k] && pq[k].size() > 0) void'(pq[k].pop_front());
      end
      prev_grant = grant;
      @(posedge clk);
      #1;
      cyc++;
    end
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_write_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid = '1;
    req_last = '0;
    req_data = '1;
    fifo_write_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (grant !== '0) begin failures++; $display("FAIL reset_grant: grant=%b, required 0000", grant); end
    checks++;
    if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: ready=%b, required 0000", req_ready); end
    checks++;
    if (fifo_write_req !== 1'b0) begin failures++; $display("FAIL reset_wreq: wreq=%b, required 0", fifo_write_req); end
    checks++;
    if (fifo_data !== '0) begin failures++; $display("FAIL reset_data: data=%h, required 00", fifo_data); end
  endtask

  task automatic test_single();
    logic [N-1:0] exp_g [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    apply_reset();
    add_beat(0, 8'hA1, 1'b0);
    add_beat(0, 8'hB2, 1'b0);
    add_beat(0, 8'hC3, 1'b1);
    sb.push_back(8'hA1); sb.push_back(8'hB2); sb.push_back(8'hC3);
    run_traffic(40, -1, 0);
    checks++;
    if (grant_hist.size() != 5) begin
      failures++;
      $display("FAIL single_cycles: cycles=%0d, required 5", grant_hist.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_hist[i] !== exp_g[i] || ready_hist[i] !== exp_g[i]) begin
          failures++;
          $display("FAIL single_cycle%0d: grant=%b ready=%b, required %b", i, grant_hist[i], ready_hist[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int b = 0; b < 8; b++) add_beat(0, {2'd0, 6'(b)}, 1'b0);
    for (int r = 1; r < N; r++)
      for (int b = 0; b < 4; b++) add_beat(r, {2'(r), 6'(b)}, 1'b0);
    for (int r = 0; r < N; r++)
      for (int b = 0; b < 4; b++) sb.push_back({2'(r), 6'(b)});
    for (int b = 4; b < 8; b++) sb.push_back({2'd0, 6'(b)});
    run_traffic(100, -1, 0);
    checks++;
    if (grant_seq.size() != 5) begin
      failures++;
      $display("FAIL rr_bursts: bursts=%0d, required 5", grant_seq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_seq[i] !== exp_seq[i] || burst_len[i] != MB) begin
          failures++;
          $display("FAIL rr_burst%0d: grant=%b beats=%0d, required %b beats=%0d", i, grant_seq[i], burst_len[i], exp_seq[i], MB);
        end
      end
    end
    checks++;
    if (idle_pending != 5) begin
      failures++;
      $display("FAIL rr_bubbles: idle cycles=%0d, required 5", idle_pending);
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      add_beat(0, 8'h40 + 8'(b), 1'b0);
      sb.push_back(8'h40 + 8'(b));
    end
    run_traffic(60, 2, 3);
    checks++;
    if (stall_seen != 3 || stall_bad != 0) begin
      failures++;
      $display("FAIL stall_hold: stall cycles=%0d bad=%0d, required 3 and 0", stall_seen, stall_bad);
    end
    checks++;
    if (burst_len.size() != 1 || burst_len[0] != 4) begin
      failures++;
      $display("FAIL stall_burst: bursts=%0d, required one burst of 4", burst_len.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    add_beat(1, 8'h11, 1'b1);
    add_beat(2, 8'h21, 1'b1);
    sb.push_back(8'h11); sb.push_back(8'h21);
    run_traffic(40, -1, 0);
    checks++;
    if (grant_seq.size() != 2 || grant_seq[0] !== 4'b0010 || grant_seq[1] !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_ptr3: first grant=%b, required 0010 then 0100", grant_seq.size() > 0 ? grant_seq[0] : 4'b0);
    end
    apply_reset();
    add_beat(1, 8'h12, 1'b1);
    sb.push_back(8'h12);
    run_traffic(40, -1, 0);
    clear_model();
    add_beat(0, 8'h01, 1'b1);
    add_beat(2, 8'h23, 1'b1);
    sb.push_back(8'h23); sb.push_back(8'h01);
    run_traffic(40, -1, 0);
    checks++;
    if (grant_seq.size() != 2 || grant_seq[0] !== 4'b0100 || grant_seq[1] !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_ptr1: first grant=%b, required 0100 then 0001", grant_seq.size() > 0 ? grant_seq[0] : 4'b0);
    end
  endtask

  task automatic test_early_last();
    logic [N-1:0] exp_seq [4] = '{4'b1000, 4'b0001, 4'b0100, 4'b1000};
    apply_reset();
    add_beat(2, 8'h2F, 1'b1);
    sb.push_back(8'h2F);
    run_traffic(40, -1, 0);
    clear_model();
    add_beat(3, 8'h30, 1'b1);
    add_beat(3, 8'h31, 1'b1);
    add_beat(0, 8'h00, 1'b1);
    add_beat(2, 8'h22, 1'b1);
    sb.push_back(8'h30); sb.push_back(8'h00); sb.push_back(8'h22); sb.push_back(8'h31);
    run_traffic(60, -1, 0);
    checks++;
    if (grant_seq.size() != 4) begin
      failures++;
      $display("FAIL early_bursts: bursts=%0d, required 4", grant_seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_seq[i] !== exp_seq[i] || burst_len[i] != 1) begin
          failures++;
          $display("FAIL early_burst%0d: grant=%b beats=%0d, required %b beats=1", i, grant_seq[i], burst_len[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_valid = 4'b0101;
    req_last = '0;
    req_data = 32'h0020_0010;
    fifo_write_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0001 || fifo_data !== 8'h10) begin
      failures++;
      $display("FAIL rstmid_beat1: grant=%b data=%h, required 0001 10", grant, fifo_data);
    end
    @(posedge clk);
    #1;
    req_data[7:0] = 8'h11;
    #1;
    checks++;
    if (fifo_write_req !== 1'b1 || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_beat2: wreq=%b ready=%b, required 1 0001", fifo_write_req, req_ready);
    end
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    $display("reset asserted mid-burst t=%0t grant=%b", $time, grant);
    checks++;
    if (grant !== '0 || fifo_write_req !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL rstmid_abort: grant=%b wreq=%b, required 0000 0", grant, fifo_write_req);
    end
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0001 || fifo_data !== 8'h11) begin
      failures++;
      $display("FAIL rstmid_restart: grant=%b data=%h, required 0001 11", grant, fifo_data);
    end
    req_valid = '0;
    req_data = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_wrap();
    test_early_last();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
